// File: rtl/lowpass_filter_sched.sv
// Scheduler that generates per-group sampling strobes for banks of lowpass filters.
// A programmable prescaler sets the tick rate. On each tick one group slot is issued
// round-robin, so at most one group samples per tick. After start or restart the
// scheduler counts full rounds and raises o_settled once the filter shift registers
// have seen enough samples.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_run           level: 1 = schedule strobes, 0 = idle
//   i_restart       pulse: restart settling from slot 0 (ignored while idle)
//   i_div_val       new prescaler value, latched by the i_div_load pulse
//   i_grp_mask      per-group enable, sampled at the tick
//   o_filter_en     one-cycle sampling strobes, at most one bit high per cycle
//   o_grp_ptr       slot that fires at the next tick
//   o_round_done    pulse issued together with the last slot of a round
//   o_settled       level: enough rounds have been issued since start or restart
//
// Optional feature: define LPF_SCHED_BROADCAST_EN to add the i_broadcast input. While
// it is high, every tick strobes all enabled groups together and counts as a full round.
module lowpass_filter_sched #(
  parameter int unsigned NUM_GRP       = 4,
  parameter int unsigned DIV_WIDTH     = 16,
  parameter int unsigned DEFAULT_DIV   = 999,
  parameter int unsigned SETTLE_ROUNDS = 7
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_run,
  input  logic                       i_restart,
  input  logic [DIV_WIDTH-1:0]       i_div_val,
  input  logic                       i_div_load,
  input  logic [NUM_GRP-1:0]         i_grp_mask,
`ifdef LPF_SCHED_BROADCAST_EN
  input  logic                       i_broadcast,
`endif
  output logic [NUM_GRP-1:0]         o_filter_en,
  output logic [$clog2(NUM_GRP)-1:0] o_grp_ptr,
  output logic                       o_round_done,
  output logic                       o_settled
);

  localparam int unsigned PtrW = $clog2(NUM_GRP);
  localparam int unsigned CntW = $clog2(SETTLE_ROUNDS + 1);

  typedef enum logic [1:0] {StIdle, StSettle, StRun} state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic [CntW-1:0]      round_q, round_d;
  logic [NUM_GRP-1:0]   en_q, en_d;
  logic                 done_q, done_d;
  logic                 settled_q, settled_d;
  logic                 tick;
  logic                 last_slot;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    round_d   = round_q;
    en_d      = '0;
    done_d    = 1'b0;
    settled_d = settled_q;
    tick      = 1'b0;
    last_slot = (ptr_q == PtrW'(NUM_GRP - 1));

    if (i_div_load) begin
      div_d = i_div_val;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d     = div_d;
        ptr_d     = '0;
        round_d   = '0;
        settled_d = 1'b0;
        if (i_run) begin
          state_d = StSettle;
        end
      end
      StSettle, StRun: begin
        if (!i_run) begin
          // Dropping run wins over restart; any pending strobe is discarded.
          state_d   = StIdle;
          cnt_d     = div_d;
          ptr_d     = '0;
          round_d   = '0;
          settled_d = 1'b0;
        end else if (i_restart) begin
          state_d   = StSettle;
          cnt_d     = div_d;
          ptr_d     = '0;
          round_d   = '0;
          settled_d = 1'b0;
        end else begin
          tick = (cnt_q == '0);
          if (tick || i_div_load) begin
            cnt_d = div_d;
          end else begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
          end

          if (tick) begin
`ifdef LPF_SCHED_BROADCAST_EN
            if (i_broadcast) begin
              en_d   = i_grp_mask;
              done_d = 1'b1;
              ptr_d  = '0;
            end else
`endif
            begin
              // Masked slots still consume their time slot.
              en_d[ptr_q] = i_grp_mask[ptr_q];
              done_d      = last_slot;
              ptr_d       = last_slot ? '0 : ptr_q + PtrW'(1);
            end

            if (done_d && (round_q < CntW'(SETTLE_ROUNDS))) begin
              round_d = round_q + CntW'(1);
            end
            // Settled is raised together with the round_done pulse that completes settling.
            if (done_d && (state_q == StSettle) && (round_d == CntW'(SETTLE_ROUNDS))) begin
              state_d   = StRun;
              settled_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      div_q     <= DIV_WIDTH'(DEFAULT_DIV);
      cnt_q     <= DIV_WIDTH'(DEFAULT_DIV);
      ptr_q     <= '0;
      round_q   <= '0;
      en_q      <= '0;
      done_q    <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      round_q   <= round_d;
      en_q      <= en_d;
      done_q    <= done_d;
      settled_q <= settled_d;
    end
  end

  assign o_filter_en  = en_q;
  assign o_grp_ptr    = ptr_q;
  assign o_round_done = done_q;
  assign o_settled    = settled_q;

endmodule
